// File: rtl/wb_load_align_stage_if.sv
// MEM2->WB bundle, stage control and WB/commit-trace outputs for wb_load_align_stage.
interface wb_load_align_stage_if;
  logic        WB_Flush;
  logic        WB_Wr;
  logic [31:0] MEM2_PC;
  logic [31:0] MEM2_ALUOut;
  logic [31:0] MEM2_OutB;
  logic [31:0] MEM2_Result;
  logic [1:0]  MEM2_WbSel;
  logic [4:0]  MEM2_Dst;
  logic        MEM2_RFWr;
  logic [2:0]  MEM2_LoadType;
  logic [31:0] MEM2_DMOut;
  logic        MEM2_DMValid;
  logic [31:0] WB_Result;
  logic [4:0]  WB_Dst;
  logic        WB_RFWr;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  // upstream side: drives the bundle, observes writeback
  modport master (
    output WB_Flush, WB_Wr, MEM2_PC, MEM2_ALUOut, MEM2_OutB, MEM2_Result,
           MEM2_WbSel, MEM2_Dst, MEM2_RFWr, MEM2_LoadType, MEM2_DMOut, MEM2_DMValid,
    input  WB_Result, WB_Dst, WB_RFWr, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  // the WB stage itself
  modport slave (
    input  WB_Flush, WB_Wr, MEM2_PC, MEM2_ALUOut, MEM2_OutB, MEM2_Result,
           MEM2_WbSel, MEM2_Dst, MEM2_RFWr, MEM2_LoadType, MEM2_DMOut, MEM2_DMValid,
    output WB_Result, WB_Dst, WB_RFWr, debug_wb_pc, debug_wb_rf_wen,
           debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_load_align_stage.sv
// Writeback stage: MEM2->WB pipeline register, dbus read-data hold buffer
// across stalls, load alignment/extension and final RF write value select.
module wb_load_align_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  wb_load_align_stage_if.slave bus
);

  localparam logic [2:0] LT_NONE = 3'b000;
  localparam logic [2:0] LT_LB   = 3'b001;
  localparam logic [2:0] LT_LBU  = 3'b010;
  localparam logic [2:0] LT_LH   = 3'b011;
  localparam logic [2:0] LT_LHU  = 3'b100;
  localparam logic [2:0] LT_LW   = 3'b101;
  localparam logic [2:0] LT_LWL  = 3'b110;
  localparam logic [2:0] LT_LWR  = 3'b111;

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} hold_st_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] outb_q, outb_d;
  logic [31:0] result_q, result_d;
  logic [31:0] dmdata_q, dmdata_d;
  logic [4:0]  dst_q, dst_d;
  logic        rfwr_q, rfwr_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [1:0]  wbsel_q, wbsel_d;
  hold_st_e    hold_st_q, hold_st_d;
  logic [31:0] hold_data_q, hold_data_d;

  // next-state: flush > write > hold; dbus data_ok parked while stalled
  always_comb begin
    pc_d        = pc_q;
    aluout_d    = aluout_q;
    outb_d      = outb_q;
    result_d    = result_q;
    dmdata_d    = dmdata_q;
    dst_d       = dst_q;
    rfwr_d      = rfwr_q;
    ldtype_d    = ldtype_q;
    wbsel_d     = wbsel_q;
    hold_st_d   = hold_st_q;
    hold_data_d = hold_data_q;
    if (bus.WB_Flush) begin
      pc_d        = RESET_PC;
      aluout_d    = '0;
      outb_d      = '0;
      result_d    = '0;
      dmdata_d    = '0;
      dst_d       = '0;
      rfwr_d      = 1'b0;
      ldtype_d    = LT_NONE;
      wbsel_d     = 2'b00;
      hold_st_d   = EMPTY;
      hold_data_d = '0;
    end else if (bus.WB_Wr) begin
      pc_d      = bus.MEM2_PC;
      aluout_d  = bus.MEM2_ALUOut;
      outb_d    = bus.MEM2_OutB;
      result_d  = bus.MEM2_Result;
      dst_d     = bus.MEM2_Dst;
      rfwr_d    = bus.MEM2_RFWr;
      ldtype_d  = bus.MEM2_LoadType;
      wbsel_d   = bus.MEM2_WbSel;
      // a parked word wins over whatever is on the bus now
      dmdata_d  = (hold_st_q == HELD) ? hold_data_q : bus.MEM2_DMOut;
      hold_st_d = EMPTY;
    end else if (hold_st_q == EMPTY && bus.MEM2_DMValid) begin
      // data_ok arrived during a stall: it will not be presented again
      hold_st_d   = HELD;
      hold_data_d = bus.MEM2_DMOut;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q        <= RESET_PC;
      aluout_q    <= '0;
      outb_q      <= '0;
      result_q    <= '0;
      dmdata_q    <= '0;
      dst_q       <= '0;
      rfwr_q      <= 1'b0;
      ldtype_q    <= LT_NONE;
      wbsel_q     <= 2'b00;
      hold_st_q   <= EMPTY;
      hold_data_q <= '0;
    end else begin
      pc_q        <= pc_d;
      aluout_q    <= aluout_d;
      outb_q      <= outb_d;
      result_q    <= result_d;
      dmdata_q    <= dmdata_d;
      dst_q       <= dst_d;
      rfwr_q      <= rfwr_d;
      ldtype_q    <= ldtype_d;
      wbsel_q     <= wbsel_d;
      hold_st_q   <= hold_st_d;
      hold_data_q <= hold_data_d;
    end
  end

  logic [1:0]  a;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign a        = aluout_q[1:0];
  assign half_sel = a[1] ? dmdata_q[31:16] : dmdata_q[15:0];

  // byte lane pick for LB/LBU
  always_comb begin
    byte_sel = dmdata_q[7:0];
    case (a)
      2'd0: byte_sel = dmdata_q[7:0];
      2'd1: byte_sel = dmdata_q[15:8];
      2'd2: byte_sel = dmdata_q[23:16];
      2'd3: byte_sel = dmdata_q[31:24];
      default: byte_sel = dmdata_q[7:0];
    endcase
  end

  // load alignment/extension; misaligned LH/LW use a[1] / ignore a
  always_comb begin
    load_data = dmdata_q;
    case (ldtype_q)
      LT_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: load_data = {24'h0, byte_sel};
      LT_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU: load_data = {16'h0, half_sel};
      LT_LW:  load_data = dmdata_q;
      LT_LWL: begin
        case (a)
          2'd0: load_data = {dmdata_q[7:0],  outb_q[23:0]};
          2'd1: load_data = {dmdata_q[15:0], outb_q[15:0]};
          2'd2: load_data = {dmdata_q[23:0], outb_q[7:0]};
          default: load_data = dmdata_q;
        endcase
      end
      LT_LWR: begin
        case (a)
          2'd0: load_data = dmdata_q;
          2'd1: load_data = {outb_q[31:24], dmdata_q[31:8]};
          2'd2: load_data = {outb_q[31:16], dmdata_q[31:16]};
          default: load_data = {outb_q[31:8], dmdata_q[31:24]};
        endcase
      end
      default: load_data = dmdata_q;
    endcase
  end

  logic [31:0] wb_result;
  assign wb_result = (wbsel_q == 2'b11 && ldtype_q != LT_NONE) ? load_data : result_q;

  assign bus.WB_Result         = wb_result;
  assign bus.WB_Dst            = dst_q;
  assign bus.WB_RFWr           = rfwr_q;
  assign bus.debug_wb_pc       = pc_q;
  assign bus.debug_wb_rf_wen   = {4{rfwr_q}};
  assign bus.debug_wb_rf_wnum  = dst_q;
  assign bus.debug_wb_rf_wdata = wb_result;

endmodule
